// File: rtl/pixel_ds_pkg.sv
// -----------------------------------------------------------------------------
// pixel_ds_pkg
// Shared definitions for the camera pixel downsampler:
//   - input format codes (RGB565 / RGB555 / RGB444)
//   - control state encoding
//   - channel-extract helper that returns each colour channel MSB-aligned
//     in a 6-bit field, so truncation and dither work the same for every format
//   - 2x2 ordered-dither weight table, used when PIXEL_DS_DITHER_EN is defined
// -----------------------------------------------------------------------------
package pixel_ds_pkg;

   localparam int FMT_RGB565 = 0;
   localparam int FMT_RGB555 = 1;
   localparam int FMT_RGB444 = 2;

   typedef enum logic [2:0] {
      IDLE,
      VBLANK,
      LINE_WAIT,
      HI,
      LO
   } state_t;

   // Each channel is left-aligned in 6 bits. Narrower channels are zero-padded
   // below, so "top N bits" is always field[5 -: N].
   typedef struct packed {
      logic [5:0] r;
      logic [5:0] g;
      logic [5:0] b;
   } chan_t;

   // Weights indexed by {y[0], x[0]}.
   localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

   function automatic chan_t extract_channels(input int fmt, input logic [15:0] pix);
      chan_t c;
      case (fmt)
         FMT_RGB555: begin
            c.r = {pix[14:10], 1'b0};
            c.g = {pix[9:5],   1'b0};
            c.b = {pix[4:0],   1'b0};
         end
         FMT_RGB444: begin
            c.r = {pix[11:8], 2'b00};
            c.g = {pix[7:4],  2'b00};
            c.b = {pix[3:0],  2'b00};
         end
         default: begin
            c.r = {pix[15:11], 1'b0};
            c.g = pix[10:5];
            c.b = {pix[4:0],   1'b0};
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pixel_ds_convert.sv
// -----------------------------------------------------------------------------
// pixel_ds_convert
// Combinational colour conversion: extract R/G/B from a 16-bit camera pixel,
// optionally add a 2x2 ordered-dither offset, and truncate to the output depth.
// The result is packed {R, B, G}, MSB first. The parent registers the output.
//
// Optional feature macro: PIXEL_DS_DITHER_EN (adds i_x0 / i_y0 ports).
//
// Ports:
//   i_pix  in  16                   assembled camera pixel {hi, lo}
//   i_x0   in  1                    (dither only) input column LSB
//   i_y0   in  1                    (dither only) input line LSB
//   o_pix  out R_OUT+G_OUT+B_OUT    packed, truncated pixel
// -----------------------------------------------------------------------------
module pixel_ds_convert
   import pixel_ds_pkg::*;
#(
   parameter int IN_FMT = 0,
   parameter int R_OUT  = 3,
   parameter int G_OUT  = 2,
   parameter int B_OUT  = 3
) (
   input  logic [15:0]                    i_pix,
`ifdef PIXEL_DS_DITHER_EN
   input  logic                           i_x0,
   input  logic                           i_y0,
`endif
   output logic [R_OUT+G_OUT+B_OUT-1:0]   o_pix
);

   localparam int OUT_W = R_OUT + G_OUT + B_OUT;

   chan_t w_ch;
   chan_t w_adj;

   assign w_ch = extract_channels(IN_FMT, i_pix);

`ifdef PIXEL_DS_DITHER_EN
   // The 2-bit weight is a quarter-step fraction of the discarded LSB range.
   // In the 6-bit aligned field that range is 2^(6-n), so the weight is shifted
   // by (4-n). Padding bits below a narrow channel absorb any sub-LSB part.
   function automatic logic [5:0] dither_sat(input logic [5:0] ch,
                                             input logic [1:0] wgt,
                                             input int         n_out);
      logic [6:0] sum;
      sum = {1'b0, ch} + (7'(wgt) << (4 - n_out));
      return sum[6] ? 6'h3F : sum[5:0];
   endfunction

   logic [1:0] w_weight;
   assign w_weight = BAYER[{i_y0, i_x0}];

   // NOTE: every field is assigned on every evaluation, so no latch is inferred.
   always_comb begin
      w_adj.r = dither_sat(w_ch.r, w_weight, R_OUT);
      w_adj.g = dither_sat(w_ch.g, w_weight, G_OUT);
      w_adj.b = dither_sat(w_ch.b, w_weight, B_OUT);
   end
`else
   assign w_adj = w_ch;
`endif

   // Shifting keeps only the top bits of each channel.
   assign o_pix = OUT_W'((18'(w_adj.r >> (6 - R_OUT)) << (B_OUT + G_OUT))
                       | (18'(w_adj.b >> (6 - B_OUT)) << G_OUT)
                       |  18'(w_adj.g >> (6 - G_OUT)));

endmodule

// File: rtl/pixel_downsampler.sv
// -----------------------------------------------------------------------------
// pixel_downsampler
// Camera byte stream (two bytes per pixel, vsync/href framing) to frame-buffer
// write port. Assembles 16-bit pixels, truncates each channel, decimates by
// H_DEC/V_DEC and emits each kept pixel with its linear write address.
//
// Optional feature macro: PIXEL_DS_DITHER_EN (2x2 ordered dither before
// truncation; same latency).
//
// Ports:
//   clk         in   1        system clock
//   reset       in   1        synchronous active-high reset
//   vsync       in   1        frame sync, high between frames
//   href        in   1        line valid
//   byte_val    in   1        byte_in valid this cycle
//   byte_in     in   8        camera byte, high byte of pixel first
//   pixel_out   out  R+G+B    packed {R,B,G}
//   pixel_val   out  1        pixel_out / wr_addr valid strobe
//   wr_addr     out  ADDR_W   y_out*(H_ACTIVE/H_DEC) + x_out
//   frame_done  out  1        one-cycle end-of-frame pulse
//   line_err    out  1        sticky: line ended on a half pixel
// -----------------------------------------------------------------------------
module pixel_downsampler
   import pixel_ds_pkg::*;
#(
   parameter int IN_FMT   = 0,
   parameter int R_OUT    = 3,
   parameter int G_OUT    = 2,
   parameter int B_OUT    = 3,
   parameter int H_ACTIVE = 176,
   parameter int V_ACTIVE = 144,
   parameter int H_DEC    = 1,
   parameter int V_DEC    = 1,
   parameter int ADDR_W   = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           vsync,
   input  logic                           href,
   input  logic                           byte_val,
   input  logic [7:0]                     byte_in,
   output logic [R_OUT+G_OUT+B_OUT-1:0]   pixel_out,
   output logic                           pixel_val,
   output logic [ADDR_W-1:0]              wr_addr,
   output logic                           frame_done,
   output logic                           line_err
);

   localparam int OUT_W = R_OUT + G_OUT + B_OUT;
   localparam int W_OUT = H_ACTIVE / H_DEC;
   localparam int XW    = $clog2(H_ACTIVE + 1);
   localparam int YW    = $clog2(V_ACTIVE + 1);

   state_t              r_state;
   logic [XW-1:0]       r_x;
   logic [YW-1:0]       r_y;
   logic [7:0]          r_hi;
   logic [ADDR_W-1:0]   r_addr;   // address of the next kept pixel
   logic [ADDR_W-1:0]   r_base;   // address of column 0 on the current output row

   logic [OUT_W-1:0]    w_conv;
   logic                w_pix_ok;
   logic                w_emit;
   logic                w_row_adv;

   assign w_pix_ok  = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));
   // Decimation factors are powers of two, so "mod" is a mask.
   assign w_emit    = ((r_x & XW'(H_DEC - 1)) == '0) && ((r_y & YW'(V_DEC - 1)) == '0);
   // The line about to start begins a new output row.
   assign w_row_adv = (((r_y + 1'b1) & YW'(V_DEC - 1)) == '0);

   pixel_ds_convert #(
      .IN_FMT (IN_FMT),
      .R_OUT  (R_OUT),
      .G_OUT  (G_OUT),
      .B_OUT  (B_OUT)
   ) u_convert (
      .i_pix  ({r_hi, byte_in}),
`ifdef PIXEL_DS_DITHER_EN
      .i_x0   (r_x[0]),
      .i_y0   (r_y[0]),
`endif
      .o_pix  (w_conv)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_hi       <= '0;
         r_addr     <= '0;
         r_base     <= '0;
         pixel_out  <= '0;
         pixel_val  <= 1'b0;
         wr_addr    <= '0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         pixel_val  <= 1'b0;
         frame_done <= 1'b0;
         if (vsync) line_err <= 1'b0;

         case (r_state)
            IDLE: begin
               if (vsync) r_state <= VBLANK;
            end

            VBLANK: begin
               r_x    <= '0;
               r_y    <= '0;
               r_addr <= '0;
               r_base <= '0;
               if (!vsync) r_state <= LINE_WAIT;
            end

            LINE_WAIT, HI, LO: begin
               if (vsync) begin
                  // Frame abort: only a frame that delivered a line reports done.
                  r_state <= VBLANK;
                  r_hi    <= '0;
                  if (r_y != '0) frame_done <= 1'b1;
               end else if (r_state == LINE_WAIT) begin
                  if (href) r_state <= HI;
               end else if (!href) begin
                  // End of line; a pending high byte is a broken pixel.
                  r_state <= LINE_WAIT;
                  r_x     <= '0;
                  if (r_state == LO) begin
                     line_err <= 1'b1;
                     r_hi     <= '0;
                  end
                  if (r_y < YW'(V_ACTIVE)) begin
                     r_y <= r_y + 1'b1;
                     if (w_row_adv) begin
                        r_base <= r_base + ADDR_W'(W_OUT);
                        r_addr <= r_base + ADDR_W'(W_OUT);
                     end else begin
                        r_addr <= r_base;
                     end
                  end
               end else if (byte_val) begin
                  if (r_state == HI) begin
                     // Bytes past the active window are dropped until href falls.
                     if (w_pix_ok) begin
                        r_hi    <= byte_in;
                        r_state <= LO;
                     end
                  end else begin
                     r_state <= HI;
                     r_x     <= r_x + 1'b1;
                     if (w_emit) begin
                        pixel_out <= w_conv;
                        pixel_val <= 1'b1;
                        wr_addr   <= r_addr;
                        r_addr    <= r_addr + 1'b1;
                     end
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_downsampler.sv
// -----------------------------------------------------------------------------
// tb_pixel_downsampler
// Three instances share one stimulus bus: default parameters, 2x2 decimation,
// and RGB444 input. Directed scenarios with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_pixel_downsampler;

   logic clk = 1'b0;
   logic reset, vsync, href, byte_val;
   logic [7:0] byte_in;

   logic [7:0]  d_pix, m_pix, f_pix;
   logic        d_val, m_val, f_val;
   logic [14:0] d_addr, m_addr, f_addr;
   logic        d_fd, m_fd, f_fd;
   logic        d_err, m_err, f_err;

   always #5 clk = ~clk;

   pixel_downsampler u_def (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .byte_val(byte_val), .byte_in(byte_in),
      .pixel_out(d_pix), .pixel_val(d_val), .wr_addr(d_addr), .frame_done(d_fd), .line_err(d_err));

   pixel_downsampler #(.H_DEC(2), .V_DEC(2)) u_dec (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .byte_val(byte_val), .byte_in(byte_in),
      .pixel_out(m_pix), .pixel_val(m_val), .wr_addr(m_addr), .frame_done(m_fd), .line_err(m_err));

   pixel_downsampler #(.IN_FMT(2)) u_f444 (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .byte_val(byte_val), .byte_in(byte_in),
      .pixel_out(f_pix), .pixel_val(f_val), .wr_addr(f_addr), .frame_done(f_fd), .line_err(f_err));

   int n_tests = 0;
   int n_fail  = 0;
   int cur_line = 0;
   logic mon_clr = 1'b1;

   // Strobe monitor, sampled on the falling edge.
   int d_cnt, m_cnt, f_cnt, d_seq_err, m_seq_err, m_odd, d_fd_cnt, m_fd_cnt;
   logic [7:0]  d_last_pix, m_last_pix, f_last_pix;
   logic [14:0] d_last_addr, m_last_addr, f_last_addr;

   always @(negedge clk) begin
      if (mon_clr) begin
         d_cnt = 0; m_cnt = 0; f_cnt = 0; d_seq_err = 0; m_seq_err = 0; m_odd = 0;
         d_fd_cnt = 0; m_fd_cnt = 0;
         d_last_pix = '0; m_last_pix = '0; f_last_pix = '0;
         d_last_addr = '0; m_last_addr = '0; f_last_addr = '0;
      end else begin
         if (d_val === 1'b1) begin
            if (d_addr !== 15'(d_cnt)) d_seq_err++;
            d_cnt++; d_last_pix = d_pix; d_last_addr = d_addr;
         end
         if (m_val === 1'b1) begin
            if (m_addr !== 15'(m_cnt)) m_seq_err++;
            if (cur_line[0]) m_odd++;
            m_cnt++; m_last_pix = m_pix; m_last_addr = m_addr;
         end
         if (f_val === 1'b1) begin
            f_cnt++; f_last_pix = f_pix; f_last_addr = f_addr;
         end
         if (d_fd === 1'b1) d_fd_cnt++;
         if (m_fd === 1'b1) m_fd_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic start_frame();
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (2) tick();
   endtask

   task automatic end_frame();
      vsync = 1'b1;
      repeat (3) tick();
   endtask

   task automatic send_pix(input logic [15:0] p);
      byte_val = 1'b1;
      byte_in  = p[15:8];
      tick();
      byte_in  = p[7:0];
      tick();
   endtask

   task automatic send_line(input int n_pix, input logic [15:0] p, input int line);
      cur_line = line;
      href = 1'b1;
      tick();
      for (int i = 0; i < n_pix; i++) send_pix(p);
      byte_val = 1'b0;
      href     = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; vsync = 1'b0; href = 1'b0; byte_val = 1'b0; byte_in = 8'h00;
      repeat (3) tick();
      @(negedge clk);
      n_tests++; if (d_pix !== 8'h00) begin n_fail++; $display("FAIL reset_pix: got %h want 00", d_pix); end
      n_tests++; if (d_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b want 0", d_val); end
      n_tests++; if (d_addr !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", d_addr); end
      n_tests++; if (d_fd !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: fd=%b err=%b want 0 0", d_fd, d_err); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      clear_mon();
      start_frame();
      cur_line = 0;
      href = 1'b1;
      tick();
      byte_val = 1'b1; byte_in = 8'hF8;
      tick();
      byte_in = 8'h1F;
      @(negedge clk);
      n_tests++; if (d_val !== 1'b0) begin n_fail++; $display("FAIL basic_early_val: got %b want 0", d_val); end
      tick();
      byte_val = 1'b0; href = 1'b0;
      @(negedge clk);
      n_tests++; if (d_val !== 1'b1) begin n_fail++; $display("FAIL basic_val: got %b want 1", d_val); end
      n_tests++; if (d_pix !== 8'hFC) begin n_fail++; $display("FAIL basic_pix: got %h want fc", d_pix); end
      n_tests++; if (d_addr !== 15'd0) begin n_fail++; $display("FAIL basic_addr: got %0d want 0", d_addr); end
      n_tests++; if (f_pix !== 8'h9C) begin n_fail++; $display("FAIL basic_444_pix: got %h want 9c", f_pix); end
      n_tests++; if (m_val !== 1'b1 || m_pix !== 8'hFC) begin n_fail++; $display("FAIL basic_dec: val=%b pix=%h want 1 fc", m_val, m_pix); end
      tick();
      @(negedge clk);
      n_tests++; if (d_val !== 1'b0) begin n_fail++; $display("FAIL basic_val_width: got %b want 0", d_val); end
      tick();
      end_frame();
      n_tests++; if (d_fd_cnt !== 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d pulses want 1", d_fd_cnt); end
   endtask

   task automatic test_convert();
      clear_mon();
      start_frame();
      send_line(1, 16'h07E0, 0);
      n_tests++; if (d_last_pix !== 8'h03 || d_last_addr !== 15'd0) begin n_fail++; $display("FAIL conv_565_g: pix=%h addr=%0d want 03 0", d_last_pix, d_last_addr); end
      n_tests++; if (f_last_pix !== 8'h63) begin n_fail++; $display("FAIL conv_444_07e0: got %h want 63", f_last_pix); end
      send_line(1, 16'h8410, 1);
      n_tests++; if (d_last_pix !== 8'h92 || d_last_addr !== 15'd176) begin n_fail++; $display("FAIL conv_565_mid: pix=%h addr=%0d want 92 176", d_last_pix, d_last_addr); end
      n_tests++; if (f_last_pix !== 8'h40) begin n_fail++; $display("FAIL conv_444_8410: got %h want 40", f_last_pix); end
      n_tests++; if (m_cnt !== 1) begin n_fail++; $display("FAIL conv_dec_odd_line: got %0d strobes want 1", m_cnt); end
      send_line(1, 16'h1234, 2);
      n_tests++; if (d_last_pix !== 8'h15 || d_last_addr !== 15'd352) begin n_fail++; $display("FAIL conv_565_1234: pix=%h addr=%0d want 15 352", d_last_pix, d_last_addr); end
      n_tests++; if (f_last_pix !== 8'h28) begin n_fail++; $display("FAIL conv_444_1234: got %h want 28", f_last_pix); end
      n_tests++; if (m_last_pix !== 8'h15 || m_last_addr !== 15'd88) begin n_fail++; $display("FAIL conv_dec_row1: pix=%h addr=%0d want 15 88", m_last_pix, m_last_addr); end
      send_line(1, 16'hAF0F, 3);
      n_tests++; if (f_last_pix !== 8'hFC) begin n_fail++; $display("FAIL conv_444_af0f: got %h want fc", f_last_pix); end
      n_tests++; if (d_last_pix !== 8'hAF || d_last_addr !== 15'd528) begin n_fail++; $display("FAIL conv_565_af0f: pix=%h addr=%0d want af 528", d_last_pix, d_last_addr); end
      send_line(1, 16'h0F0F, 4);
      n_tests++; if (f_last_pix !== 8'hFC) begin n_fail++; $display("FAIL conv_444_ignore_hi: got %h want fc", f_last_pix); end
      n_tests++; if (d_last_pix !== 8'h0F || d_last_addr !== 15'd704) begin n_fail++; $display("FAIL conv_565_0f0f: pix=%h addr=%0d want 0f 704", d_last_pix, d_last_addr); end
      n_tests++; if (m_last_pix !== 8'h0F || m_last_addr !== 15'd176) begin n_fail++; $display("FAIL conv_dec_row2: pix=%h addr=%0d want 0f 176", m_last_pix, m_last_addr); end
      end_frame();
      n_tests++; if (d_fd_cnt !== 1) begin n_fail++; $display("FAIL conv_frame_done: got %0d pulses want 1", d_fd_cnt); end
   endtask

   task automatic test_partial_line();
      clear_mon();
      start_frame();
      cur_line = 0;
      href = 1'b1;
      tick();
      byte_val = 1'b1;
      byte_in = 8'hF8; tick();
      byte_in = 8'h1F; tick();
      byte_in = 8'hAA; tick();
      byte_val = 1'b0; href = 1'b0;
      tick(); tick();
      @(negedge clk);
      n_tests++; if (d_cnt !== 1 || d_last_pix !== 8'hFC) begin n_fail++; $display("FAIL partial_pixels: cnt=%0d pix=%h want 1 fc", d_cnt, d_last_pix); end
      n_tests++; if (d_err !== 1'b1 || m_err !== 1'b1) begin n_fail++; $display("FAIL partial_line_err: got %b/%b want 1/1", d_err, m_err); end
      send_line(1, 16'h07E0, 1);
      n_tests++; if (d_cnt !== 2 || d_last_pix !== 8'h03 || d_last_addr !== 15'd176) begin n_fail++; $display("FAIL partial_next_line: cnt=%0d pix=%h addr=%0d want 2 03 176", d_cnt, d_last_pix, d_last_addr); end
      n_tests++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL partial_err_sticky: got %b want 1", d_err); end
      end_frame();
      @(negedge clk);
      n_tests++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL partial_err_clear: got %b want 0", d_err); end
   endtask

   task automatic test_idle_bytes();
      clear_mon();
      start_frame();
      byte_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         byte_in = 8'(8'h11 * (i + 1));
         tick();
      end
      byte_val = 1'b0;
      tick();
      n_tests++; if (d_cnt !== 0) begin n_fail++; $display("FAIL idle_bytes_ignored: got %0d strobes want 0", d_cnt); end
      send_line(1, 16'h8410, 0);
      n_tests++; if (d_cnt !== 1 || d_last_pix !== 8'h92 || d_last_addr !== 15'd0) begin n_fail++; $display("FAIL idle_then_line: cnt=%0d pix=%h addr=%0d want 1 92 0", d_cnt, d_last_pix, d_last_addr); end
      end_frame();
   endtask

   task automatic test_empty_frame();
      clear_mon();
      start_frame();
      repeat (3) tick();
      end_frame();
      n_tests++; if (d_fd_cnt !== 0) begin n_fail++; $display("FAIL empty_frame_done: got %0d pulses want 0", d_fd_cnt); end
   endtask

   task automatic test_bounds();
      clear_mon();
      start_frame();
      send_line(180, 16'hF81F, 0);
      n_tests++; if (d_cnt !== 176 || m_cnt !== 88) begin n_fail++; $display("FAIL bounds_h_count: got %0d/%0d want 176/88", d_cnt, m_cnt); end
      send_line(1, 16'hF81F, 1);
      n_tests++; if (d_last_addr !== 15'd176 || d_seq_err !== 0) begin n_fail++; $display("FAIL bounds_next_addr: addr=%0d seq_err=%0d want 176 0", d_last_addr, d_seq_err); end
      n_tests++; if (m_last_addr !== 15'd87 || m_cnt !== 88) begin n_fail++; $display("FAIL bounds_dec_addr: addr=%0d cnt=%0d want 87 88", m_last_addr, m_cnt); end
      end_frame();
   endtask

   task automatic test_reset_midline();
      clear_mon();
      start_frame();
      send_line(2, 16'h8410, 0);
      cur_line = 1;
      href = 1'b1;
      tick();
      byte_val = 1'b1; byte_in = 8'hF8;
      tick();
      byte_in = 8'h1F; reset = 1'b1;
      tick();
      @(negedge clk);
      n_tests++; if (d_val !== 1'b0 || d_pix !== 8'h00 || d_addr !== 15'd0) begin n_fail++; $display("FAIL rst_mid_outputs: val=%b pix=%h addr=%0d want 0 00 0", d_val, d_pix, d_addr); end
      reset = 1'b0;
      repeat (3) tick();
      byte_val = 1'b0; href = 1'b0;
      tick();
      n_tests++; if (d_cnt !== 2) begin n_fail++; $display("FAIL rst_mid_no_strobe: got %0d strobes want 2", d_cnt); end
      start_frame();
      send_line(1, 16'hF81F, 0);
      n_tests++; if (d_cnt !== 3 || d_last_addr !== 15'd0 || d_last_pix !== 8'hFC) begin n_fail++; $display("FAIL rst_mid_new_frame: cnt=%0d addr=%0d pix=%h want 3 0 fc", d_cnt, d_last_addr, d_last_pix); end
      end_frame();
   endtask

   task automatic test_full_frame();
      clear_mon();
      start_frame();
      for (int y = 0; y < 144; y++) send_line(176, 16'h5A3C, y);
      @(negedge clk);
      n_tests++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL full_line_err: got %b want 0", d_err); end
      end_frame();
      n_tests++; if (d_cnt !== 25344 || d_last_addr !== 15'd25343) begin n_fail++; $display("FAIL full_def_count: cnt=%0d last=%0d want 25344 25343", d_cnt, d_last_addr); end
      n_tests++; if (d_seq_err !== 0) begin n_fail++; $display("FAIL full_def_addr_seq: got %0d errors want 0", d_seq_err); end
      n_tests++; if (d_fd_cnt !== 1) begin n_fail++; $display("FAIL full_def_frame_done: got %0d pulses want 1", d_fd_cnt); end
      n_tests++; if (m_cnt !== 6336 || m_last_addr !== 15'd6335) begin n_fail++; $display("FAIL full_dec_count: cnt=%0d last=%0d want 6336 6335", m_cnt, m_last_addr); end
      n_tests++; if (m_seq_err !== 0 || m_odd !== 0) begin n_fail++; $display("FAIL full_dec_seq_odd: seq_err=%0d odd=%0d want 0 0", m_seq_err, m_odd); end
      n_tests++; if (m_fd_cnt !== 1) begin n_fail++; $display("FAIL full_dec_frame_done: got %0d pulses want 1", m_fd_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_convert();
      test_partial_line();
      test_idle_bytes();
      test_empty_frame();
      test_bounds();
      test_reset_midline();
      test_full_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
